// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the jzjpcc instruction memory: the nop encoding,
// the loader FSM states and a byte-merge helper used by the program loader.
package jzjpcc_pkg;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   // Place a byte into lane 'index' of a word and clear every lane above it,
   // so a word closed early by the last byte is zero-padded at the top.
   function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                              input logic [1:0]  index,
                                              input logic [7:0]  data);
      logic [31:0] result;
      result = word;
      for (int i = 0; i < 4; i++) begin
         if (i == int'(index)) begin
            result[8*i +: 8] = data;
         end else if (i > int'(index)) begin
            result[8*i +: 8] = 8'h00;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/jzjpcc_imem_sram.sv
// Single-port-read instruction RAM: one write port plus a registered read
// address feeding an asynchronous array read, the shape block-RAM inference
// maps onto M9K blocks.
module jzjpcc_imem_sram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [31:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [31:0]          rdata
);

   logic [31:0]          mem [DEPTH_WORDS];
   logic [ADDR_BITS-1:0] raddr_p0;

   // Write port; contents survive reset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read address register, latched every edge regardless of core stall.
   always_ff @(posedge clock) begin
      if (!reset) begin
         raddr_p0 <= '0;
      end else begin
         raddr_p0 <= raddr;
      end
   end

   // ---- stage p0: registered address -> array output ----
   assign rdata = mem[raddr_p0];

endmodule

// File: rtl/jzjpcc_instruction_memory.sv
// Fetch-side instruction memory with a byte-stream program loader. The
// loader packs little-endian bytes into words, writes them into the RAM and
// holds the core while an image is streaming in.
module jzjpcc_instruction_memory
   import jzjpcc_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:2] instructionAddressToLatch,
   output logic [31:0] instruction_fetch,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        load_ready,
   output logic        coreHold,
   output logic        load_done
);

   loader_state_t        state;
   loader_state_t        state_next;
   logic [1:0]           byte_index;
   logic [ADDR_BITS-1:0] word_count;
   logic [31:0]          byte_buffer;
   logic [31:0]          merged_word;
   logic                 write_en;
   logic                 accept;
   logic                 read_primed;
   logic [31:0]          ram_rdata;
   logic                 unused_addr;

   // Address bits above the decoded range are deliberately ignored.
   assign unused_addr = ^instructionAddressToLatch;

   assign accept      = load_valid && load_ready;
   assign merged_word = merge_byte(byte_buffer, byte_index, load_byte);

   jzjpcc_imem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_BITS   (ADDR_BITS)
   ) u_sram (
      .clock (clock),
      .reset (reset),
      .we    (write_en),
      .waddr (word_count),
      .wdata (merged_word),
      .raddr (instructionAddressToLatch[ADDR_BITS+1:2]),
      .rdata (ram_rdata)
   );

   // Loader state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, handshake and write-strobe decode for the loader.
   always_comb begin
      state_next = state;
      load_ready = 1'b0;
      coreHold   = 1'b0;
      load_done  = 1'b0;
      write_en   = 1'b0;
      unique case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               if (load_last) begin
                  write_en   = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            coreHold   = 1'b1;
            if (load_valid) begin
               if (load_last || byte_index == 2'd3) begin
                  write_en = 1'b1;
               end
               if (load_last) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            coreHold   = 1'b1;
            load_done  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Byte packing: index and buffer advance per accepted byte; a word write
   // resets the lane index and bumps the word counter, which wraps freely.
   always_ff @(posedge clock) begin
      if (!reset) begin
         byte_index  <= 2'd0;
         word_count  <= '0;
         byte_buffer <= 32'h0;
      end else if (state == DONE) begin
         byte_index  <= 2'd0;
         word_count  <= '0;
         byte_buffer <= 32'h0;
      end else if (accept) begin
         if (write_en) begin
            byte_index  <= 2'd0;
            word_count  <= word_count + 1'b1;
            byte_buffer <= 32'h0;
         end else begin
            byte_index  <= byte_index + 2'd1;
            byte_buffer <= merged_word;
         end
      end
   end

   // The reset-state address points at uninitialised memory, so the output
   // stays nop until a real fetch address has been latched.
   always_ff @(posedge clock) begin
      if (!reset) begin
         read_primed <= 1'b0;
      end else begin
         read_primed <= 1'b1;
      end
   end

   assign instruction_fetch = (state == IDLE && read_primed) ? ram_rdata : NOP_INSTRUCTION;

endmodule

// File: tb/tb_jzjpcc_instruction_memory.sv
// Scoreboard bench: a 1024-word and a 4-word instance share all stimulus;
// expectations are queued with the cycle they become due and a monitor
// compares both instances on the falling edge.
module tb_jzjpcc_instruction_memory;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:2] addr;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic [31:0] fetch_big, fetch_small;
   logic        ready_big, ready_small;
   logic        hold_big, hold_small;
   logic        done_big, done_small;

   always #5 clock = ~clock;

   jzjpcc_instruction_memory #(.DEPTH_WORDS(1024)) dut_big (
      .clock                     (clock),
      .reset                     (reset),
      .instructionAddressToLatch (addr),
      .instruction_fetch         (fetch_big),
      .load_valid                (load_valid),
      .load_byte                 (load_byte),
      .load_last                 (load_last),
      .load_ready                (ready_big),
      .coreHold                  (hold_big),
      .load_done                 (done_big)
   );

   jzjpcc_instruction_memory #(.DEPTH_WORDS(4)) dut_small (
      .clock                     (clock),
      .reset                     (reset),
      .instructionAddressToLatch (addr),
      .instruction_fetch         (fetch_small),
      .load_valid                (load_valid),
      .load_byte                 (load_byte),
      .load_last                 (load_last),
      .load_ready                (ready_small),
      .coreHold                  (hold_small),
      .load_done                 (done_small)
   );

   // sig: 0 fetch, 1 coreHold, 2 load_ready, 3 load_done, 4 load_done pulse count
   typedef struct {
      string       name;
      int          due;
      int          sig;
      logic [31:0] exp_big;
      logic [31:0] exp_small;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pulses_big = 0;
   int   pulses_small = 0;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic check_entry(input exp_t e);
      logic [31:0] act_big, act_small;
      case (e.sig)
         0:       begin act_big = fetch_big;            act_small = fetch_small;            end
         1:       begin act_big = {31'b0, hold_big};    act_small = {31'b0, hold_small};    end
         2:       begin act_big = {31'b0, ready_big};   act_small = {31'b0, ready_small};   end
         3:       begin act_big = {31'b0, done_big};    act_small = {31'b0, done_small};    end
         default: begin act_big = 32'(pulses_big);      act_small = 32'(pulses_small);      end
      endcase
      n_cmp++;
      if (act_big !== e.exp_big || e.due != cyc) begin
         n_bad++;
         $display("FAIL %s (depth1024) cycle %0d: got %h, expected %h", e.name, cyc, act_big, e.exp_big);
      end
      n_cmp++;
      if (act_small !== e.exp_small || e.due != cyc) begin
         n_bad++;
         $display("FAIL %s (depth4) cycle %0d: got %h, expected %h", e.name, cyc, act_small, e.exp_small);
      end
   endtask

   // Monitor: count load_done pulses, then retire every expectation now due.
   initial forever begin
      @(negedge clock);
      if (done_big === 1'b1) pulses_big++;
      if (done_small === 1'b1) pulses_small++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         check_entry(sb.pop_front());
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input string name, input int due, input int sig,
                            input logic [31:0] eb, input logic [31:0] es);
      exp_t e;
      e.name      = name;
      e.due       = due;
      e.sig       = sig;
      e.exp_big   = eb;
      e.exp_small = es;
      sb.push_back(e);
   endtask

   task automatic expect_now(input string name, input int sig,
                             input logic [31:0] eb, input logic [31:0] es);
      expect_at(name, cyc, sig, eb, es);
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic read_word(input string name, input logic [31:2] a,
                            input logic [31:0] eb, input logic [31:0] es);
      addr = a;
      expect_at(name, cyc + 1, 0, eb, es);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] seq1 [8];
      logic [7:0] seq2 [5];
      logic [7:0] b;
      int guard;

      seq1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      seq2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h6F};

      reset      = 1'b0;
      addr       = '0;
      load_valid = 1'b0;
      load_byte  = 8'h00;
      load_last  = 1'b0;
      step();
      step();
      expect_now("rst_fetch", 0, NOP, NOP);
      expect_now("rst_hold",  1, 0, 0);
      expect_now("rst_ready", 2, 1, 1);
      expect_now("rst_done",  3, 0, 0);
      reset = 1'b1;
      step();

      // Two-word image: nop then addi x1,x0,1
      for (int i = 0; i < 8; i++) begin
         send(seq1[i], i == 7);
         if (i == 0) begin
            expect_now("l1_hold_after_first", 1, 1, 1);
            expect_now("l1_fetch_nop_loading", 0, NOP, NOP);
         end
      end
      expect_now("l1_done_pulse", 3, 1, 1);
      expect_now("l1_done_hold",  1, 1, 1);
      expect_now("l1_done_ready", 2, 0, 0);
      expect_now("l1_done_fetch", 0, NOP, NOP);
      step();
      expect_now("l1_idle_done", 3, 0, 0);
      expect_now("l1_idle_hold", 1, 0, 0);
      read_word("l1_word0", 30'd0, 32'h00000013, 32'h00000013);
      read_word("l1_word1", 30'd1, 32'h00100093, 32'h00100093);
      expect_now("l1_pulse_count", 4, 1, 1);

      // Five bytes: second word zero-padded
      for (int i = 0; i < 5; i++) send(seq2[i], i == 4);
      step();
      read_word("l2_word0", 30'd0, 32'hDEADBEEF, 32'hDEADBEEF);
      read_word("l2_word1", 30'd1, 32'h0000006F, 32'h0000006F);
      expect_now("l2_pulse_count", 4, 2, 2);

      // Valid toggling every cycle
      for (int i = 0; i < 4; i++) begin
         b = 8'(i + 1);
         send(b, i == 3);
         if (i < 3) begin
            expect_now("l3_gap_hold",  1, 1, 1);
            expect_now("l3_gap_ready", 2, 1, 1);
            step();
         end
      end
      step();
      read_word("l3_word0", 30'd0, 32'h04030201, 32'h04030201);
      read_word("l3_word1_untouched", 30'd1, 32'h0000006F, 32'h0000006F);
      expect_now("l3_pulse_count", 4, 3, 3);

      // Reset after 6 of 8 bytes
      for (int i = 0; i < 6; i++) begin
         b = 8'h11 * 8'(i + 1);
         send(b, 1'b0);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      expect_now("l4_rst_hold",  1, 0, 0);
      expect_now("l4_rst_ready", 2, 1, 1);
      expect_now("l4_rst_done",  3, 0, 0);
      expect_now("l4_rst_fetch", 0, NOP, NOP);
      step();
      read_word("l4_word0_kept", 30'd0, 32'h44332211, 32'h44332211);
      read_word("l4_word1_unchanged", 30'd1, 32'h0000006F, 32'h0000006F);
      expect_now("l4_pulse_count", 4, 3, 3);

      // 20 bytes: the 4-word instance wraps onto word 0
      for (int i = 0; i < 20; i++) begin
         b = 8'hA0 + 8'(i);
         send(b, i == 19);
      end
      step();
      read_word("l5_word0", 30'd0, 32'hA3A2A1A0, 32'hB3B2B1B0);
      read_word("l5_addr4_alias", 30'd4, 32'hB3B2B1B0, 32'hB3B2B1B0);
      read_word("l5_high_bits_ignored", 30'h20000401, 32'hA7A6A5A4, 32'hA7A6A5A4);
      read_word("l5_word3", 30'd3, 32'hAFAEADAC, 32'hAFAEADAC);
      expect_now("l5_pulse_count", 4, 4, 4);

      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         step();
         guard++;
      end
      if (sb.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
